// File: rtl/wb_stream_reader_ctrl.sv
// -----------------------------------------------------------------------------
// wb_stream_reader_ctrl
//
// Drains a first-word-fall-through FIFO into a linear memory buffer using
// Wishbone incrementing bursts. A transfer is started by a one-cycle enable
// pulse. The buffer is cut into bursts of at most burst_size words (also capped
// by MAX_BURST_LEN and by the words still to go). A burst is only issued once
// the FIFO holds enough words to complete it without stalling.
//
// Ports
//   wb_clk_i, wb_rst_n_i   clock, asynchronous active-low reset
//   wbm_adr_o/dat_o/sel_o  write address (byte), write data, byte selects
//   wbm_we_o/cyc_o/stb_o   Wishbone master controls (all high during a burst)
//   wbm_cti_o/bte_o        cycle type (010 incrementing, 111 last) / burst type
//   wbm_dat_i              read data, not used by a write-only master
//   wbm_ack_i/err_i/rty_i  slave terminations (rty is treated as a wait state)
//   fifo_q, fifo_cnt       FIFO head word and fill level
//   fifo_rd                FIFO pop strobe, high on every accepted beat
//   start_adr              byte base address of the buffer
//   buf_size, burst_size   total words, words per burst (0 behaves as 1)
//   enable                 start pulse, ignored while busy
//   busy                   transfer in progress
//   irq                    one-cycle pulse when a transfer completes
//   error                  sticky bus-error flag, cleared by the next enable
// -----------------------------------------------------------------------------
module wb_stream_reader_ctrl #(
    parameter int WB_AW         = 32,
    parameter int WB_DW         = 32,
    parameter int FIFO_AW       = 4,
    parameter int MAX_BURST_LEN = 2**FIFO_AW
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n_i,
    output logic [WB_AW-1:0]   wbm_adr_o,
    output logic [WB_DW-1:0]   wbm_dat_o,
    output logic [WB_DW/8-1:0] wbm_sel_o,
    output logic               wbm_we_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic [2:0]         wbm_cti_o,
    output logic [1:0]         wbm_bte_o,
    input  logic [WB_DW-1:0]   wbm_dat_i,
    input  logic               wbm_ack_i,
    input  logic               wbm_err_i,
    input  logic               wbm_rty_i,
    input  logic [WB_DW-1:0]   fifo_q,
    output logic               fifo_rd,
    input  logic [FIFO_AW:0]   fifo_cnt,
    input  logic [WB_AW-1:0]   start_adr,
    input  logic [WB_AW-1:0]   buf_size,
    input  logic [WB_AW-1:0]   burst_size,
    input  logic               enable,
    output logic               busy,
    output logic               irq,
    output logic               error
);

    localparam int               BL_W     = $clog2(MAX_BURST_LEN + 1);
    localparam logic [WB_AW-1:0] MAX_BL   = WB_AW'(MAX_BURST_LEN);
    localparam logic [WB_AW-1:0] WORD_B   = WB_AW'(WB_DW / 8);
    localparam logic [WB_AW-1:0] ONE_W    = WB_AW'(1);
    localparam logic [BL_W-1:0]  ONE_BL   = BL_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [WB_AW-1:0]  r_start_adr, w_start_adr_nxt;
    logic [WB_AW-1:0]  r_buf_size, w_buf_size_nxt;
    logic [WB_AW-1:0]  r_burst_size, w_burst_size_nxt;
    logic [WB_AW-1:0]  r_word_idx, w_word_idx_nxt;
    logic [BL_W-1:0]   r_beat_cnt, w_beat_cnt_nxt;
    logic [BL_W-1:0]   r_burst_len, w_burst_len_nxt;
    logic              r_irq, w_irq_nxt;
    logic              r_error, w_error_nxt;

    logic [WB_AW-1:0]  w_remaining;
    logic [WB_AW-1:0]  w_len_a;
    logic [WB_AW-1:0]  w_len;
    logic [WB_AW-1:0]  w_fifo_cnt;
    logic              w_in_burst;
    logic              w_last_beat;
    logic              w_pop;
    logic              w_unused;

    // Read data is never consumed by this write-only master.
    assign w_unused = ^wbm_dat_i;

    always_comb begin
        w_remaining = r_buf_size - r_word_idx;
        w_len_a     = (r_burst_size < w_remaining) ? r_burst_size : w_remaining;
        w_len       = (w_len_a < MAX_BL) ? w_len_a : MAX_BL;
        w_fifo_cnt  = WB_AW'(fifo_cnt);
        w_in_burst  = (r_state == ST_BURST);
        w_last_beat = (r_beat_cnt == (r_burst_len - ONE_BL));
        // A retry or error termination never consumes the head word.
        w_pop       = w_in_burst & wbm_ack_i & ~wbm_err_i & ~wbm_rty_i;
    end

    // Next-state and register-update logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_start_adr_nxt  = r_start_adr;
        w_buf_size_nxt   = r_buf_size;
        w_burst_size_nxt = r_burst_size;
        w_word_idx_nxt   = r_word_idx;
        w_beat_cnt_nxt   = r_beat_cnt;
        w_burst_len_nxt  = r_burst_len;
        w_irq_nxt        = 1'b0;
        w_error_nxt      = r_error;

        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_start_adr_nxt  = start_adr;
                    w_buf_size_nxt   = buf_size;
                    w_burst_size_nxt = (burst_size == '0) ? ONE_W : burst_size;
                    w_word_idx_nxt   = '0;
                    w_error_nxt      = 1'b0;
                    // An empty buffer completes immediately without a bus cycle.
                    if (buf_size == '0) begin
                        w_irq_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                // Only start once the whole burst is already in the FIFO.
                if (w_fifo_cnt >= w_len) begin
                    w_state_nxt     = ST_BURST;
                    w_burst_len_nxt = w_len[BL_W-1:0];
                    w_beat_cnt_nxt  = '0;
                end
            end

            ST_BURST: begin
                if (wbm_err_i) begin
                    w_state_nxt = ST_IDLE;
                    w_error_nxt = 1'b1;
                end else if (w_pop) begin
                    w_word_idx_nxt = r_word_idx + ONE_W;
                    w_beat_cnt_nxt = r_beat_cnt + ONE_BL;
                    if (w_last_beat) begin
                        if (w_remaining == ONE_W) begin
                            w_state_nxt = ST_IDLE;
                            w_irq_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = ST_WAIT;
                        end
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state      <= ST_IDLE;
            r_start_adr  <= '0;
            r_buf_size   <= '0;
            r_burst_size <= '0;
            r_word_idx   <= '0;
            r_beat_cnt   <= '0;
            r_burst_len  <= '0;
            r_irq        <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_start_adr  <= w_start_adr_nxt;
            r_buf_size   <= w_buf_size_nxt;
            r_burst_size <= w_burst_size_nxt;
            r_word_idx   <= w_word_idx_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
            r_burst_len  <= w_burst_len_nxt;
            r_irq        <= w_irq_nxt;
            r_error      <= w_error_nxt;
        end
    end

    // Bus outputs are decoded from the state register, so an asynchronous
    // reset clears all of them in the same instant it forces IDLE.
    always_comb begin
        wbm_cyc_o = w_in_burst;
        wbm_stb_o = w_in_burst;
        wbm_we_o  = w_in_burst;
        wbm_bte_o = 2'b00;
        fifo_rd   = w_pop;
        if (w_in_burst) begin
            wbm_adr_o = r_start_adr + (r_word_idx * WORD_B);
            wbm_dat_o = fifo_q;
            wbm_sel_o = '1;
            wbm_cti_o = w_last_beat ? 3'b111 : 3'b010;
        end else begin
            wbm_adr_o = '0;
            wbm_dat_o = '0;
            wbm_sel_o = '0;
            wbm_cti_o = 3'b000;
        end
    end

    assign busy  = (r_state != ST_IDLE);
    assign irq   = r_irq;
    assign error = r_error;

endmodule

// File: tb/tb_wb_stream_reader_ctrl.sv
module tb_wb_stream_reader_ctrl;

    localparam int MBL = 16;

    logic        clk;
    logic        rst_n;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic        wbm_rty_i;
    logic [31:0] fifo_q;
    logic        fifo_rd;
    logic [4:0]  fifo_cnt;
    logic [31:0] start_adr;
    logic [31:0] buf_size;
    logic [31:0] burst_size;
    logic        enable;
    logic        busy;
    logic        irq;
    logic        error;

    wb_stream_reader_ctrl #(
        .WB_AW(32), .WB_DW(32), .FIFO_AW(4), .MAX_BURST_LEN(MBL)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_cti_o  (wbm_cti_o),
        .wbm_bte_o  (wbm_bte_o),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_ack_i  (wbm_ack_i),
        .wbm_err_i  (wbm_err_i),
        .wbm_rty_i  (wbm_rty_i),
        .fifo_q     (fifo_q),
        .fifo_rd    (fifo_rd),
        .fifo_cnt   (fifo_cnt),
        .start_adr  (start_adr),
        .buf_size   (buf_size),
        .burst_size (burst_size),
        .enable     (enable),
        .busy       (busy),
        .irq        (irq),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: transaction-level view of what the bus must show.
    bit          m_busy, m_cyc, m_err, m_irq;
    logic [31:0] exp_adr[$];
    logic [2:0]  exp_cti[$];
    int          bl[$];

    // FIFO environment and observation logs.
    logic [31:0] fq[$];
    logic [31:0] log_adr[$];
    logic [2:0]  log_cti[$];
    int          n_pops, n_irq, cyc_no;

    // Stimulus policy.
    bit auto_stim, spam;
    int ack_pct, rty_pct, err_pct, push_pct, push_every;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp_v, $time);
        end
    endfunction

    task automatic drive_fifo();
        fifo_q   = (fq.size() > 0) ? fq[0] : 32'h0;
        fifo_cnt = 5'(fq.size());
    endtask

    task automatic prefill(input int n);
        for (int i = 0; i < n; i++) if (fq.size() < 16) fq.push_back($urandom());
        drive_fifo();
    endtask

    task automatic flush();
        fq.delete();
        drive_fifo();
    endtask

    task automatic clear_logs();
        log_adr.delete();
        log_cti.delete();
        n_pops = 0;
        n_irq  = 0;
    endtask

    task automatic model_reset();
        m_busy = 0; m_cyc = 0; m_err = 0; m_irq = 0;
        exp_adr.delete(); exp_cti.delete(); bl.delete();
    endtask

    // Expected beat list for a whole transfer: address and cti of every beat.
    task automatic build_plan();
        int rem, bs, len;
        logic [31:0] a;
        rem = int'(buf_size);
        bs  = (burst_size == 0) ? 1 : int'(burst_size);
        a   = start_adr;
        while (rem > 0) begin
            len = bs;
            if (rem < len) len = rem;
            if (MBL < len) len = MBL;
            for (int j = 0; j < len; j++) begin
                exp_adr.push_back(a);
                exp_cti.push_back((j == len - 1) ? 3'b111 : 3'b010);
                a = a + 32'd4;
            end
            bl.push_back(len);
            rem -= len;
        end
    endtask

    task automatic check_outputs();
        logic [31:0] hd;
        hd = (fq.size() > 0) ? fq[0] : 32'h0;
        chk("busy", busy, m_busy);
        chk("irq", irq, m_irq);
        chk("error", error, m_err);
        chk("cyc", wbm_cyc_o, m_cyc);
        chk("stb", wbm_stb_o, m_cyc);
        chk("we", wbm_we_o, m_cyc);
        chk("fifo_rd", fifo_rd, m_cyc && wbm_ack_i && !wbm_err_i && !wbm_rty_i);
        if (m_cyc && exp_adr.size() > 0) begin
            chk("adr", wbm_adr_o, exp_adr[0]);
            chk("cti", wbm_cti_o, exp_cti[0]);
            chk("dat", wbm_dat_o, hd);
            chk("sel", wbm_sel_o, 4'hF);
            chk("bte", wbm_bte_o, 2'b00);
        end else begin
            chk("adr_idle", wbm_adr_o, 32'h0);
            chk("cti_idle", wbm_cti_o, 3'b000);
        end
    endtask

    // Advance the model by one cycle using the inputs present this cycle.
    task automatic model_update();
        bit nirq;
        logic [2:0] c;
        nirq = 0;
        if (!m_busy) begin
            if (enable) begin
                m_err = 0;
                if (buf_size == 0) nirq = 1;
                else begin
                    build_plan();
                    m_busy = 1;
                end
            end
        end else if (!m_cyc) begin
            if (int'(fifo_cnt) >= bl[0]) m_cyc = 1;
        end else begin
            if (wbm_err_i) begin
                m_cyc = 0; m_busy = 0; m_err = 1;
                exp_adr.delete(); exp_cti.delete(); bl.delete();
            end else if (wbm_ack_i && !wbm_rty_i) begin
                c = exp_cti.pop_front();
                void'(exp_adr.pop_front());
                if (c == 3'b111) begin
                    m_cyc = 0;
                    void'(bl.pop_front());
                    if (exp_adr.size() == 0) begin
                        m_busy = 0;
                        nirq   = 1;
                    end
                end
            end
        end
        m_irq = nirq;
    endtask

    task automatic step();
        logic rd;
        bit   push;
        @(negedge clk);
        check_outputs();
        rd = fifo_rd;
        if (wbm_cyc_o && wbm_ack_i && !wbm_err_i && !wbm_rty_i) begin
            log_adr.push_back(wbm_adr_o);
            log_cti.push_back(wbm_cti_o);
        end
        if (fifo_rd) n_pops++;
        if (irq) n_irq++;
        model_update();
        @(posedge clk);
        #1;
        cyc_no++;
        if (rd && fq.size() > 0) void'(fq.pop_front());
        if (push_every > 0) push = (cyc_no % push_every == 0);
        else                push = ($urandom_range(0, 99) < push_pct);
        if (push && fq.size() < 16) fq.push_back($urandom());
        drive_fifo();
        if (auto_stim) begin
            wbm_rty_i = ($urandom_range(0, 99) < rty_pct);
            wbm_err_i = !wbm_rty_i && ($urandom_range(0, 99) < err_pct);
            wbm_ack_i = !wbm_rty_i && !wbm_err_i && ($urandom_range(0, 99) < ack_pct);
            enable    = spam && m_busy && ($urandom_range(0, 99) < 5);
            if (enable) begin
                start_adr  = $urandom();
                buf_size   = 32'($urandom_range(0, 24));
                burst_size = 32'($urandom_range(0, 20));
            end
        end
    endtask

    task automatic start_xfer(input logic [31:0] sa, input logic [31:0] bs_words, input logic [31:0] burst);
        start_adr  = sa;
        buf_size   = bs_words;
        burst_size = burst;
        enable     = 1'b1;
        step();
        if (!auto_stim) enable = 1'b0;
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((m_busy || m_irq) && n < budget) begin
            step();
            n++;
        end
        chk("xfer_within_budget", m_busy || m_irq, 0);
        step();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          given, rty_cnt, pops_before;
    bit          done, was_err;
    logic [31:0] wrap_adr[4];

    initial begin
        rst_n = 1'b0;
        wbm_dat_i = 32'h0; wbm_ack_i = 0; wbm_err_i = 0; wbm_rty_i = 0;
        start_adr = 0; buf_size = 0; burst_size = 0; enable = 0;
        auto_stim = 0; spam = 0; ack_pct = 100; rty_pct = 0; err_pct = 0;
        push_pct = 0; push_every = 0; cyc_no = 0;
        model_reset();
        clear_logs();
        drive_fifo();

        #1;
        chk("rst_cyc", wbm_cyc_o, 0);
        chk("rst_stb", wbm_stb_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_irq", irq, 0);
        chk("rst_error", error, 0);
        chk("rst_fifo_rd", fifo_rd, 0);
        chk("rst_adr", wbm_adr_o, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Two 4-beat bursts from a full FIFO, ack every cycle.
        prefill(8); clear_logs();
        auto_stim = 1; ack_pct = 100;
        start_xfer(32'h1000, 8, 4);
        run_until_idle(200);
        chk("a_beats", log_adr.size(), 8);
        for (int i = 0; i < 8 && i < log_adr.size(); i++) begin
            chk("a_adr", log_adr[i], 32'h1000 + 32'(4 * i));
            chk("a_cti", log_cti[i], (i % 4 == 3) ? 3'b111 : 3'b010);
        end
        chk("a_pops", n_pops, 8);
        chk("a_irq", n_irq, 1);

        // Slow fill: one word every 3 cycles, bursts of 4 then 1.
        flush(); clear_logs(); push_every = 3;
        start_xfer(32'h3000, 5, 4);
        run_until_idle(300);
        push_every = 0;
        chk("b_beats", log_cti.size(), 5);
        if (log_cti.size() == 5) begin
            chk("b_cti0", log_cti[0], 3'b010);
            chk("b_cti3", log_cti[3], 3'b111);
            chk("b_cti4", log_cti[4], 3'b111);
            chk("b_adr4", log_adr[4], 32'h3010);
        end
        chk("b_irq", n_irq, 1);

        // Error on the second beat of a 4-beat burst.
        flush(); prefill(4); clear_logs();
        auto_stim = 0; wbm_ack_i = 0; wbm_err_i = 0; wbm_rty_i = 0;
        start_xfer(32'h2000, 4, 4);
        given = 0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            wbm_ack_i = m_cyc && (given == 0);
            wbm_err_i = m_cyc && (given > 0);
            was_err   = m_cyc && (given > 0);
            if (m_cyc) given++;
            step();
            if (was_err) done = 1;
        end
        wbm_ack_i = 0; wbm_err_i = 0;
        chk("c_err_seen", done, 1);
        chk("c_cyc_next", wbm_cyc_o, 0);
        step(); step();
        chk("c_pops", n_pops, 1);
        chk("c_error", error, 1);
        chk("c_busy", busy, 0);
        chk("c_irq", n_irq, 0);

        // Address wrap at the top of the address space.
        flush(); prefill(4); clear_logs();
        auto_stim = 1; ack_pct = 100;
        start_xfer(32'hFFFF_FFF8, 4, 4);
        run_until_idle(100);
        wrap_adr[0] = 32'hFFFF_FFF8; wrap_adr[1] = 32'hFFFF_FFFC;
        wrap_adr[2] = 32'h0000_0000; wrap_adr[3] = 32'h0000_0004;
        chk("d_beats", log_adr.size(), 4);
        for (int i = 0; i < 4 && i < log_adr.size(); i++) chk("d_adr", log_adr[i], wrap_adr[i]);
        chk("d_error_cleared", error, 0);

        // Zero-length buffer.
        clear_logs();
        start_xfer(32'h8000, 0, 4);
        run_until_idle(10);
        chk("e_irq", n_irq, 1);
        chk("e_beats", log_adr.size(), 0);

        // Enable pulse during a transfer is ignored.
        flush(); clear_logs(); push_every = 2;
        start_xfer(32'h4000, 6, 3);
        step(); step(); step();
        enable = 1; start_adr = 32'h9000; buf_size = 2; burst_size = 1;
        step();
        run_until_idle(300);
        push_every = 0;
        chk("f_beats", log_adr.size(), 6);
        if (log_adr.size() == 6) begin
            chk("f_adr5", log_adr[5], 32'h4014);
            chk("f_cti2", log_cti[2], 3'b111);
        end

        // Reset in the middle of a burst.
        flush(); prefill(16); clear_logs();
        start_xfer(32'h5000, 16, 16);
        for (int i = 0; i < 30 && log_adr.size() < 3; i++) step();
        rst_n = 1'b0;
        #1;
        chk("g_cyc", wbm_cyc_o, 0);
        chk("g_stb", wbm_stb_o, 0);
        chk("g_we", wbm_we_o, 0);
        chk("g_busy", busy, 0);
        chk("g_irq", irq, 0);
        chk("g_fifo_rd", fifo_rd, 0);
        chk("g_cti", wbm_cti_o, 0);
        chk("g_adr", wbm_adr_o, 0);
        model_reset();
        pops_before = n_pops;
        step(); step();
        chk("g_no_pop", n_pops, pops_before);
        rst_n = 1'b1;
        clear_logs();
        start_xfer(32'h6000, 2, 2);
        run_until_idle(100);
        chk("g_fresh_beats", log_adr.size(), 2);
        if (log_adr.size() == 2) begin
            chk("g_fresh_adr0", log_adr[0], 32'h6000);
            chk("g_fresh_adr1", log_adr[1], 32'h6004);
        end

        // Three retry cycles, then ack: one pop, address held throughout.
        flush(); prefill(1); clear_logs();
        auto_stim = 0; wbm_ack_i = 0; wbm_rty_i = 0; wbm_err_i = 0;
        start_xfer(32'h7000, 1, 1);
        rty_cnt = 0;
        for (int i = 0; i < 30 && (m_busy || m_irq); i++) begin
            wbm_rty_i = m_cyc && (rty_cnt < 3);
            wbm_ack_i = m_cyc && (rty_cnt >= 3);
            if (m_cyc) rty_cnt++;
            step();
        end
        wbm_rty_i = 0; wbm_ack_i = 0;
        step();
        chk("h_pops", n_pops, 1);
        chk("h_beats", log_adr.size(), 1);
        if (log_adr.size() == 1) begin
            chk("h_adr", log_adr[0], 32'h7000);
            chk("h_cti", log_cti[0], 3'b111);
        end
        chk("h_irq", n_irq, 1);

        // Randomized transfers against the model.
        auto_stim = 1; spam = 1;
        for (int t = 0; t < 40; t++) begin
            ack_pct  = $urandom_range(30, 100);
            rty_pct  = $urandom_range(0, 20);
            err_pct  = (t % 5 == 4) ? 3 : 0;
            push_pct = $urandom_range(20, 100);
            start_xfer((t % 4 == 0) ? (32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3))) : $urandom(),
                       32'($urandom_range(0, 24)), 32'($urandom_range(0, 20)));
            run_until_idle(3000);
        end
        auto_stim = 0; spam = 0; enable = 0;
        wbm_ack_i = 0; wbm_err_i = 0; wbm_rty_i = 0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
